// File: rtl/display_decoder.sv
// Majority-vote segment decoder: integrates NB_FRAMES displayed frames
// and emits one recovered segment message per decision window.
module display_decoder #(
    parameter int NB_SEGMENTS = 120,
    parameter int NB_FRAMES   = 16,
    parameter int THRESHOLD   = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   frm_valid,
    output logic                   frm_ready,
    input  logic [NB_SEGMENTS-1:0] frm_seg,
    output logic                   msg_valid,
    input  logic                   msg_ready,
    output logic [NB_SEGMENTS-1:0] msg_out,
    output logic                   busy
);

    localparam int CNT_W = $clog2(NB_FRAMES + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(NB_FRAMES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NB_FRAMES - 1);
    localparam logic [CNT_W-1:0] THR  = CNT_W'(THRESHOLD);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DECIDE,
        HOLD
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q [NB_SEGMENTS];
    logic [CNT_W-1:0] frames_q;
    logic             clear;
    logic             accept;

    assign frm_ready = (state_q == ACCUM);
    assign busy      = (state_q != IDLE);

    // start has priority over a frame presented in the same ACCUM cycle
    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    clear   = 1'b1;
                end
            end
            ACCUM: begin
                if (start) begin
                    clear = 1'b1;
                end else if (frm_valid) begin
                    accept = 1'b1;
                    if (frames_q == LAST) begin
                        state_d = DECIDE;
                    end
                end
            end
            DECIDE: state_d = HOLD;
            HOLD: begin
                if (msg_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_q <= '0;
            for (int i = 0; i < NB_SEGMENTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (clear) begin
            frames_q <= '0;
            for (int i = 0; i < NB_SEGMENTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (accept) begin
            if (frames_q != FULL) begin
                frames_q <= frames_q + ONE;
            end
            for (int i = 0; i < NB_SEGMENTS; i++) begin
                if (frm_seg[i] && (cnt_q[i] != FULL)) begin
                    cnt_q[i] <= cnt_q[i] + ONE;
                end
            end
        end
    end

    // msg_out is only rewritten in DECIDE, so it keeps the last message
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_valid <= 1'b0;
            msg_out   <= '0;
        end else if (state_q == DECIDE) begin
            msg_valid <= 1'b1;
            for (int i = 0; i < NB_SEGMENTS; i++) begin
                msg_out[i] <= (cnt_q[i] >= THR);
            end
        end else if ((state_q == HOLD) && msg_ready) begin
            msg_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_display_decoder.sv
// Randomized scoreboard bench for display_decoder, plus a small
// NB_FRAMES=4 instance exercised with directed windows.
module tb_display_decoder;

    localparam int NS = 120;
    localparam int NF = 16;
    localparam int TH = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          frm_valid;
    logic          frm_ready;
    logic [NS-1:0] frm_seg;
    logic          msg_valid;
    logic          msg_ready;
    logic [NS-1:0] msg_out;
    logic          busy;

    logic          s_start;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    s_seg;
    logic          s_mvalid;
    logic          s_mready;
    logic [7:0]    s_out;
    logic          s_busy;

    always #5 clk = ~clk;

    display_decoder #(
        .NB_SEGMENTS(NS),
        .NB_FRAMES  (NF),
        .THRESHOLD  (TH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .frm_valid(frm_valid),
        .frm_ready(frm_ready),
        .frm_seg  (frm_seg),
        .msg_valid(msg_valid),
        .msg_ready(msg_ready),
        .msg_out  (msg_out),
        .busy     (busy)
    );

    display_decoder #(
        .NB_SEGMENTS(8),
        .NB_FRAMES  (4),
        .THRESHOLD  (4)
    ) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (s_start),
        .frm_valid(s_valid),
        .frm_ready(s_ready),
        .frm_seg  (s_seg),
        .msg_valid(s_mvalid),
        .msg_ready(s_mready),
        .msg_out  (s_out),
        .busy     (s_busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NS-1:0] msg;
        int            acc_cyc;
    } exp_t;

    exp_t sb[$];

    // window-level model: 0 idle, 1 collecting, 2 deciding, 3 presenting
    int mphase = 0;
    int mn = 0;
    int mcnt[NS];

    function automatic void chk_v(string name, logic [NS-1:0] act,
                                  logic [NS-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    function automatic void chk_i(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endfunction

    function automatic logic [NS-1:0] rnd();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[NS-1:0];
    endfunction

    function automatic void mclear();
        mn = 0;
        for (int i = 0; i < NS; i++) mcnt[i] = 0;
    endfunction

    // One clock cycle: drive at negedge, check handshake outputs, update model.
    task automatic cycle(input bit st, input bit v,
                         input logic [NS-1:0] seg, input bit rdy);
        bit            done;
        logic [NS-1:0] m;
        done = 1'b0;
        m = '0;
        start = st;
        frm_valid = v;
        frm_seg = seg;
        msg_ready = rdy;
        chk_i("frm_ready", int'(frm_ready), int'(mphase == 1));
        chk_i("busy", int'(busy), int'(mphase != 0));
        chk_i("msg_valid", int'(msg_valid), int'(mphase == 3));
        @(posedge clk);
        case (mphase)
            0: if (st) begin
                mphase = 1;
                mclear();
            end
            1: if (st) begin
                mclear();
            end else if (v) begin
                for (int i = 0; i < NS; i++) if (seg[i]) mcnt[i]++;
                mn++;
                if (mn == NF) begin
                    mphase = 2;
                    done = 1'b1;
                    for (int i = 0; i < NS; i++) m[i] = (mcnt[i] >= TH);
                end
            end
            2: mphase = 3;
            3: if (rdy) mphase = 0;
            default: mphase = 0;
        endcase
        @(negedge clk);
        if (done) sb.push_back('{msg: m, acc_cyc: cyc});
    endtask

    // Randomized window; optional restart after 8 frames and a HOLD stall.
    task automatic window(input int hold_wait, input bit restart8,
                          input int density);
        int guard;
        logic [NS-1:0] s;
        cycle(1'b1, 1'b0, rnd(), 1'b0);
        if (restart8) begin
            for (int f = 0; f < 8; f++) cycle(1'b0, 1'b1, rnd(), 1'b0);
            cycle(1'b1, 1'b1, '1, 1'b0);
        end
        guard = 0;
        while (mphase == 1 && guard < 400) begin
            s = rnd();
            if (density > 0) s = s | rnd();
            if (density > 1) s = s | rnd();
            cycle(1'b0, ($urandom % 4) != 0, s, 1'b0);
            guard++;
        end
        chk_i("window_timeout", int'(mphase == 1), 0);
        for (int k = 0; k < hold_wait + 2; k++)
            cycle(1'(($urandom % 2)), 1'b1, rnd(), 1'b0);
        cycle(1'b1, 1'b1, rnd(), 1'b1);
        cycle(1'b0, 1'b1, rnd(), 1'b0);
    endtask

    bit            mv_prev = 1'b0;
    logic [NS-1:0] held = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (msg_valid && !mv_prev) begin
                if (sb.size() == 0) begin
                    chk_i("spurious_msg", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk_v("msg_out", msg_out, e.msg);
                    chk_i("latency", cyc, e.acc_cyc + 1);
                end
                held = msg_out;
            end else if (msg_valid) begin
                chk_v("hold_stable", msg_out, held);
            end else if (mv_prev) begin
                chk_i("busy_after_ack", int'(busy), 0);
                chk_v("msg_retained", msg_out, held);
            end
            mv_prev = msg_valid;
        end else begin
            mv_prev = 1'b0;
        end
    end

    task automatic sstep(input bit st, input bit v, input logic [7:0] seg,
                         input bit rdy);
        s_start = st;
        s_valid = v;
        s_seg = seg;
        s_mready = rdy;
        @(negedge clk);
    endtask

    initial begin
        logic [NS-1:0] s;
        rst_n = 1'b1;
        start = 1'b0;
        frm_valid = 1'b0;
        frm_seg = '0;
        msg_ready = 1'b0;
        s_start = 1'b0;
        s_valid = 1'b0;
        s_seg = '0;
        s_mready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_i("rst_frm_ready", int'(frm_ready), 0);
        chk_i("rst_msg_valid", int'(msg_valid), 0);
        chk_i("rst_busy", int'(busy), 0);
        chk_v("rst_msg_out", msg_out, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // idle ignores frames; then the directed 16-frame window
        cycle(1'b0, 1'b1, '1, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b1);
        for (int f = 0; f < NF; f++) begin
            s = '0;
            s[0] = 1'b1;
            s[1] = (f < 12);
            s[2] = (f < 11);
            cycle(1'b0, 1'b1, s, 1'b1);
        end
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, '0, 1'b1);

        window(10, 1'b0, 2);
        window(0, 1'b1, 2);
        window(3, 1'b0, 1);
        window(1, 1'b1, 0);

        // asynchronous reset between edges in the middle of a window
        cycle(1'b1, 1'b0, '0, 1'b0);
        for (int f = 0; f < 5; f++) cycle(1'b0, 1'b1, rnd(), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_i("mid_rst_frm_ready", int'(frm_ready), 0);
        chk_i("mid_rst_busy", int'(busy), 0);
        chk_i("mid_rst_msg_valid", int'(msg_valid), 0);
        chk_v("mid_rst_msg_out", msg_out, '0);
        mphase = 0;
        mclear();
        @(negedge clk);
        rst_n = 1'b1;
        window(2, 1'b0, 2);

        // NB_FRAMES=4, THRESHOLD=4 instance
        sstep(1'b1, 1'b0, 8'h00, 1'b0);
        for (int f = 0; f < 4; f++)
            sstep(1'b0, 1'b1,
                  8'h81 | ((f < 3) ? 8'h02 : 8'h00) | ((f > 0) ? 8'h04 : 8'h00),
                  1'b0);
        chk_i("s_ready_after", int'(s_ready), 0);
        for (int k = 0; k < 5; k++) sstep(1'b0, 1'b1, 8'hff, 1'b0);
        chk_v("s_msg_out", NS'(s_out), NS'(8'h81));
        chk_i("s_msg_valid", int'(s_mvalid), 1);
        sstep(1'b0, 1'b0, 8'h00, 1'b1);
        chk_i("s_ack_valid", int'(s_mvalid), 0);
        chk_i("s_ack_busy", int'(s_busy), 0);
        sstep(1'b1, 1'b0, 8'h00, 1'b0);
        for (int f = 0; f < 4; f++) sstep(1'b0, 1'b1, 8'hff, 1'b0);
        sstep(1'b0, 1'b1, 8'hff, 1'b0);
        sstep(1'b0, 1'b0, 8'h00, 1'b1);
        chk_v("s_msg_all", NS'(s_out), NS'(8'hff));
        chk_i("s_valid2", int'(s_mvalid), 0);

        chk_i("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
